// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
// Shared definitions for the push-button conditioner:
//   chan_state_e : per-channel debounce FSM state encoding (3 bits)
//   cnt_width()  : bit width needed for a counter that must hold values up to
//                  and including max_count
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

    typedef enum logic [2:0] {
        LOCKOUT     = 3'd0,  // wait for a clean released level before arming
        IDLE        = 3'd1,  // armed, button released
        PRESS_CHK   = 3'd2,  // press seen, qualifying stability
        HELD        = 3'd3,  // press accepted
        RELEASE_CHK = 3'd4   // release seen, qualifying stability
    } chan_state_e;

    // ceil(log2(max_count+1)): enough bits to represent 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Bundles the button pins and the conditioned outputs of one button bank.
//   but_raw   : raw active-high button pins (1 = pressed)
//   but_level : debounced level per channel
//   but_pulse : one-clock press pulse per channel
// Modports:
//   master : the side that owns the pins and consumes the conditioned outputs
//   slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int unsigned N_BUT = 5
);

    logic [N_BUT-1:0] but_raw;
    logic [N_BUT-1:0] but_level;
    logic [N_BUT-1:0] but_pulse;

    modport master (
        output but_raw,
        input  but_level,
        input  but_pulse
    );

    modport slave (
        input  but_raw,
        output but_level,
        output but_pulse
    );

endinterface

// File: rtl/button_conditioner_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One push-button channel: 2-flop synchronizer, 5-state debounce FSM and a
// saturating stability counter.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous reset, active low
//   raw   : asynchronous button pin, 1 = pressed
//   level : registered debounced level (1 in HELD / RELEASE_CHK)
//   pulse : registered one-clock pulse, first cycle of HELD after a press
// -----------------------------------------------------------------------------
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             cnt_done;

    // The counter only ever advances while below CNT_MAX, so it saturates
    // there instead of wrapping.
    assign cnt_done = (cnt_q == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchronizer chain
    // depends on this).
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= LOCKOUT;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            // A button held through reset keeps clearing the counter, so it
            // cannot arm until it has been seen released for the full window.
            LOCKOUT: begin
                if (sync2_q) begin
                    cnt_d = '0;
                end else if (cnt_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                // Bouncing back high returns to HELD without a new pulse.
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOCKOUT;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state register rather than lagging it by a cycle.
        level_d = (state_d == HELD) || (state_d == RELEASE_CHK);
        pulse_d = (state_q == PRESS_CHK) && (state_d == HELD);
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Bank of N_BUT independent debounced push-button channels.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous reset, active low
//   but_raw   : asynchronous button pins, 1 = pressed
//   but_level : debounced level per channel
//   but_pulse : one-clock press pulse per channel
// Parameters:
//   N_BUT           : number of channels
//   DEBOUNCE_CYCLES : stable samples needed to accept a change (2..2^24-1)
// -----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned N_BUT           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BUT-1:0] but_raw,
    output logic [N_BUT-1:0] but_level,
    output logic [N_BUT-1:0] but_pulse
);

    for (genvar i = 0; i < N_BUT; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (but_raw[i]),
            .level(but_level[i]),
            .pulse(but_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner with N_BUT=5, DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the following rising edge. Edge index k=0 is the first edge that
// samples a new raw value; a clean press shows level/pulse at k=6.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N = 5;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    button_conditioner_if #(.N_BUT(N)) bus ();

    button_conditioner #(
        .N_BUT          (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .but_raw  (bus.but_raw),
        .but_level(bus.but_level),
        .but_pulse(bus.but_pulse)
    );

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] lvl;
        logic [N-1:0] pls;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    int npulse  [N];
    int first_k [N];
    int lvl_low [N];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [N-1:0] raw, input logic [N-1:0] lvl,
                            input logic [N-1:0] pls);
        vec_t v;
        v.raw = raw;
        v.lvl = lvl;
        v.pls = pls;
        vecs.push_back(v);
    endtask

    // Run a fixed number of cycles, recording per channel the pulse count,
    // the index of the first pulse (-1 if none) and how many sampled cycles
    // at index >= from_k had level low.
    task automatic watch(input int cycles, input int from_k);
        for (int b = 0; b < N; b++) begin
            npulse[b]  = 0;
            first_k[b] = -1;
            lvl_low[b] = 0;
        end
        for (int k = 0; k < cycles; k++) begin
            tick();
            for (int b = 0; b < N; b++) begin
                if (bus.but_pulse[b] === 1'b1) begin
                    npulse[b]++;
                    if (first_k[b] < 0) first_k[b] = k;
                end
                if (k >= from_k && bus.but_level[b] !== 1'b1) lvl_low[b]++;
            end
        end
    endtask

    initial begin
        int p_sum;
        int low_sum;
        int first_save;

        // Basic press/release of channel 2 from IDLE, one vector per cycle.
        for (int k = 0; k < 10; k++)
            push_vec(5'b00100, (k >= 6) ? 5'b00100 : 5'b00000,
                     (k == 6) ? 5'b00100 : 5'b00000);
        for (int k = 0; k < 10; k++)
            push_vec(5'b00000, (k < 6) ? 5'b00100 : 5'b00000, 5'b00000);

        // Reset state.
        rst         = 1'b0;
        bus.but_raw = '0;
        repeat (3) tick();
        check("reset_level", 32'(bus.but_level), 32'(0));
        check("reset_pulse", 32'(bus.but_pulse), 32'(0));
        rst = 1'b1;
        repeat (10) tick();
        check("idle_level", 32'(bus.but_level), 32'(0));

        // Table-driven press/release.
        foreach (vecs[i]) begin
            bus.but_raw = vecs[i].raw;
            tick();
            check($sformatf("vec%0d_level", i), 32'(bus.but_level), 32'(vecs[i].lvl));
            check($sformatf("vec%0d_pulse", i), 32'(bus.but_pulse), 32'(vecs[i].pls));
        end

        // Bouncing press on channel 0, then a clean settle.
        p_sum = 0;
        for (int t = 0; t < 4; t++) begin
            bus.but_raw[0] = (t % 2 == 0);
            watch(2, 0);
            p_sum += npulse[0];
        end
        check("bounce_no_pulse", 32'(p_sum), 32'(0));
        bus.but_raw[0] = 1'b1;
        watch(12, 6);
        check("settle_pulse_k", first_k[0], 32'(6));
        check("settle_pulse_n", 32'(npulse[0]), 32'(1));
        check("settle_others", 32'(npulse[1] + npulse[2] + npulse[3] + npulse[4]), 32'(0));
        bus.but_raw = '0;
        repeat (12) tick();

        // Long hold on channel 1 with a 2-cycle glitch; no auto-repeat.
        bus.but_raw[1] = 1'b1;
        watch(100, 6);
        first_save = first_k[1];
        p_sum      = npulse[1];
        low_sum    = lvl_low[1];
        bus.but_raw[1] = 1'b0;
        watch(2, 0);
        p_sum   += npulse[1];
        low_sum += lvl_low[1];
        bus.but_raw[1] = 1'b1;
        watch(98, 0);
        p_sum   += npulse[1];
        low_sum += lvl_low[1];
        check("hold_first_k", first_save, 32'(6));
        check("hold_one_pulse", 32'(p_sum), 32'(1));
        check("hold_level_steady", 32'(low_sum), 32'(0));
        bus.but_raw = '0;
        repeat (12) tick();

        // Button held across reset release: locked out until released.
        bus.but_raw[3] = 1'b1;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        watch(30, 0);
        check("lock_no_pulse", 32'(npulse[3]), 32'(0));
        check("lock_level_low", 32'(lvl_low[3]), 32'(30));
        bus.but_raw[3] = 1'b0;
        repeat (10) tick();
        bus.but_raw[3] = 1'b1;
        watch(12, 6);
        check("relock_pulse_k", first_k[3], 32'(6));
        check("relock_pulse_n", 32'(npulse[3]), 32'(1));
        bus.but_raw = '0;
        repeat (12) tick();

        // Simultaneous presses on channels 0 and 4.
        bus.but_raw = 5'b10001;
        watch(12, 6);
        check("sim_ch0_k", first_k[0], 32'(6));
        check("sim_ch4_k", first_k[4], 32'(6));
        check("sim_ch0_n", 32'(npulse[0]), 32'(1));
        check("sim_ch4_n", 32'(npulse[4]), 32'(1));
        check("sim_others", 32'(npulse[1] + npulse[2] + npulse[3]), 32'(0));
        check("sim_level", 32'(bus.but_level), 32'(5'b10001));
        bus.but_raw = '0;
        repeat (12) tick();

        // Reset while channel 2 is HELD.
        bus.but_raw[2] = 1'b1;
        watch(10, 6);
        check("held_before_rst", 32'(lvl_low[2]), 32'(0));
        rst = 1'b0;
        tick();
        check("rst_held_level", 32'(bus.but_level), 32'(0));
        check("rst_held_pulse", 32'(bus.but_pulse), 32'(0));
        rst = 1'b1;
        watch(20, 0);
        check("after_rst_no_pulse", 32'(npulse[2]), 32'(0));
        check("after_rst_level_low", 32'(lvl_low[2]), 32'(20));
        bus.but_raw[2] = 1'b0;
        repeat (10) tick();
        bus.but_raw[2] = 1'b1;
        watch(12, 6);
        check("after_rst_press_k", first_k[2], 32'(6));
        check("after_rst_press_n", 32'(npulse[2]), 32'(1));
        bus.but_raw = '0;
        repeat (12) tick();

        // Reset on the very edge that would issue the pulse drops it.
        bus.but_raw[2] = 1'b1;
        repeat (6) tick();
        check("pre_pulse_level", 32'(bus.but_level), 32'(0));
        rst = 1'b0;
        tick();
        check("pending_pulse_drop", 32'(bus.but_pulse), 32'(0));
        check("pending_level_drop", 32'(bus.but_level), 32'(0));
        rst         = 1'b1;
        bus.but_raw = '0;
        repeat (12) tick();
        check("final_level", 32'(bus.but_level), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BUT, default 5, number of independent push-button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), stable-sample count required to accept a level change; legal range 2..2^24-1.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (rst==0 resets on the next clk edge).
REQ-005 SHALL have port but_raw  input  N_BUT  asynchronous active-high button pins, 1 = pressed.
REQ-006 SHALL have port but_level  output  N_BUT  debounced button level per channel.
REQ-007 SHALL have port but_pulse  output  N_BUT  one-clk press pulse per channel; feeds the game FSM's mid_but.

Function
REQ-008 SHALL pass each but_raw bit through a 2-flop synchronizer; sync output is the only raw value the FSM sees.
REQ-009 SHALL run one independent 5-state FSM and one counter per channel: LOCKOUT, IDLE, PRESS_CHK, HELD, RELEASE_CHK.
REQ-010 LOCKOUT: sync==1 -> counter cleared, stay; sync==0 -> count; counter reaching DEBOUNCE_CYCLES-1 -> IDLE.
REQ-011 IDLE: sync==1 -> PRESS_CHK with counter cleared; else stay.
REQ-012 PRESS_CHK: sync==0 -> IDLE (bounce rejected, no pulse); counter reaching DEBOUNCE_CYCLES-1 with sync==1 -> HELD.
REQ-013 HELD: sync==0 -> RELEASE_CHK with counter cleared; else stay.
REQ-014 RELEASE_CHK: sync==1 -> HELD (no new pulse); counter reaching DEBOUNCE_CYCLES-1 with sync==0 -> IDLE.
REQ-015 SHALL drive but_level=1 in HELD and RELEASE_CHK, 0 in LOCKOUT, IDLE, PRESS_CHK; registered output.
REQ-016 SHALL assert but_pulse for exactly one clk, in the cycle after the PRESS_CHK->HELD transition; registered output.
REQ-017 Latency: raw rising edge sampled at edge t and held clean -> but_level and but_pulse go high at edge t+2+DEBOUNCE_CYCLES.
REQ-018 SHALL emit at most one pulse per accepted press regardless of hold duration; no auto-repeat.
REQ-019 Counter SHALL saturate/never wrap; width = ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-020 Simultaneous presses on several channels SHALL each produce their own pulse in the same cycle if their timing coincides; channels never interact.
REQ-021 Illegal/unused FSM encodings SHALL return to LOCKOUT on the next clk.

Reset
REQ-022 On rst==0: all FSMs -> LOCKOUT, counters 0, synchronizer flops 0, but_level 0, but_pulse 0.
REQ-023 A button held across reset release SHALL produce no pulse until released for DEBOUNCE_CYCLES and pressed again.
REQ-024 Reset asserted mid-press (PRESS_CHK or HELD) SHALL drop but_level and any pending pulse in the same edge.

Structure
REQ-025 Shared package SHALL hold the channel-state encoding (LOCKOUT, IDLE, PRESS_CHK, HELD, RELEASE_CHK, 3 bits) and the counter-width function.
REQ-026 SHALL instantiate N_BUT copies of sub-module button_channel (synchronizer + FSM + counter, one bit in, level/pulse out) via generate loop.

Verification (DEBOUNCE_CYCLES=4, N_BUT=5)
REQ-027 Reset with all raw=0, hold 0 for 10 clk, raw[2]=1 steady -> level[2]=1 and pulse[2] one clk, both 6 clk after first sampled 1; others stay 0.
REQ-028 raw[0] toggles 1,0,1,0 every 2 clk then settles 1 -> no pulse during toggling; exactly one pulse 6 clk after final settle.
REQ-029 Hold raw[1]=1 for 200 clk with a 2-clk 0 glitch at clk 100 -> exactly one pulse total, level[1] stays 1 throughout.
REQ-030 raw[3]=1 during and after reset release -> no pulse; release 10 clk, press again -> one pulse.
REQ-031 raw[0] and raw[4] rise on same edge -> pulse[0] and pulse[4] high in the same cycle, each one clk.
REQ-032 rst=0 pulsed while level[2]=1 -> level[2]=0 on that edge, no pulse; channel returns via LOCKOUT.
